// File: rtl/vga_timing.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing
// Purpose  : Raster timing generator for a VGA-style display. Free-running
//            horizontal/vertical pixel counters with sync, visible-region and
//            tick decode. Defaults give 640x480 @ 60 Hz from a 25 MHz clock.
// Ports    : clk        - pixel clock (single clock domain)
//            rst        - synchronous, active-high reset
//            hsync      - horizontal sync, active low
//            vsync      - vertical sync, active low
//            active     - high while the current pixel is visible
//            x, y       - current horizontal / vertical counter values
//            line_tick  - one-cycle pulse on the last pixel of every line
//            frame_tick - one-cycle pulse on the first pixel of vertical
//                         blanking (hcnt == 0, vcnt == V_ACTIVE)
//            frame_cnt  - 16-bit frame counter
// Options  : VGA_FRAME_CNT_EN - when defined, frame_cnt counts frame_tick
//            pulses (wrapping at 0xFFFF); otherwise frame_cnt is tied to 0
//            and no counter register exists.
// Limits   : H_TOTAL and V_TOTAL must not exceed 1024 (10-bit counters).
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        rst,
  output logic        hsync,
  output logic        vsync,
  output logic        active,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        line_tick,
  output logic        frame_tick,
  output logic [15:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  // Decode thresholds are one bit wider than the counters so that a region
  // ending exactly at 1024 (e.g. zero back porch) does not wrap to 0.
  localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT_END  = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYNC_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] H_LAST_W   = 11'(H_TOTAL - 1);

  logic [9:0]  hcnt_q, hcnt_d;
  logic [9:0]  vcnt_q, vcnt_d;
  logic        h_wrap;
  logic [10:0] h_nxt_w, v_nxt_w;

  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;
  logic active_q, active_d;
  logic line_tick_q, line_tick_d;
  logic frame_tick_q, frame_tick_d;

  // --------------------------------------------------------------------------
  // Counter next-state. Reset is folded into the next-state value so that
  // the decoded flops below see the post-reset position (0,0) as well.
  // --------------------------------------------------------------------------
  always_comb begin
    h_wrap = (hcnt_q == H_LAST);
    hcnt_d = h_wrap ? 10'd0 : hcnt_q + 10'd1;
    vcnt_d = vcnt_q;
    if (h_wrap) begin
      vcnt_d = (vcnt_q == V_LAST) ? 10'd0 : vcnt_q + 10'd1;
    end
    if (rst) begin
      hcnt_d = 10'd0;
      vcnt_d = 10'd0;
    end
  end

  // --------------------------------------------------------------------------
  // Output decode. Each output is computed from the *next* counter values
  // and registered alongside the counters, so it lines up with x/y in the
  // same cycle yet leaves the chip straight from a flop: sync pulses are
  // glitch-free.
  // --------------------------------------------------------------------------
  always_comb begin
    h_nxt_w      = {1'b0, hcnt_d};
    v_nxt_w      = {1'b0, vcnt_d};
    hsync_d      = !((h_nxt_w >= H_SYNC_BEG) && (h_nxt_w < H_SYNC_END));
    vsync_d      = !((v_nxt_w >= V_SYNC_BEG) && (v_nxt_w < V_SYNC_END));
    active_d     = (h_nxt_w < H_ACT_END) && (v_nxt_w < V_ACT_END);
    line_tick_d  = (h_nxt_w == H_LAST_W);
    frame_tick_d = (h_nxt_w == 11'd0) && (v_nxt_w == V_ACT_END);
  end

  always_ff @(posedge clk) begin
    hcnt_q       <= hcnt_d;
    vcnt_q       <= vcnt_d;
    hsync_q      <= hsync_d;
    vsync_q      <= vsync_d;
    active_q     <= active_d;
    // Ticks are suppressed while reset is held so none escape during reset.
    line_tick_q  <= line_tick_d & ~rst;
    frame_tick_q <= frame_tick_d & ~rst;
  end

  assign x          = hcnt_q;
  assign y          = vcnt_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign active     = active_q;
  assign line_tick  = line_tick_q;
  assign frame_tick = frame_tick_q;

  // --------------------------------------------------------------------------
  // Optional frame counter: advances on the edge that closes the frame_tick
  // cycle, so it reads the new frame number from the following pixel on.
  // --------------------------------------------------------------------------
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_tick_q) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= 16'h0000;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_timing.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing
// Purpose  : Directed self-checking bench for vga_timing. Instance A uses the
//            default 640x480 timing for reset and line checks; instance B
//            uses a small raster (15 x 11) so whole frames stay short.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing;

  logic clk;
  logic rst_a, rst_b;

  logic        hsync_a, vsync_a, active_a, line_tick_a, frame_tick_a;
  logic [9:0]  x_a, y_a;
  logic [15:0] frame_cnt_a;

  logic        hsync_b, vsync_b, active_b, line_tick_b, frame_tick_b;
  logic [9:0]  x_b, y_b;
  logic [15:0] frame_cnt_b;

  int n_pass  = 0;
  int n_total = 0;

  // Small raster for instance B: H 8+2+3+2 = 15, V 6+2+2+1 = 11.
  localparam int BH_ACT = 8, BH_FP = 2, BH_SYNC = 3, BH_BP = 2;
  localparam int BV_ACT = 6, BV_FP = 2, BV_SYNC = 2, BV_BP = 1;
  localparam int BH_TOT = BH_ACT + BH_FP + BH_SYNC + BH_BP;
  localparam int BV_TOT = BV_ACT + BV_FP + BV_SYNC + BV_BP;

`ifdef VGA_FRAME_CNT_EN
  localparam int FCNT_EN = 1;
`else
  localparam int FCNT_EN = 0;
`endif

  vga_timing u_dut_a (
    .clk        (clk),
    .rst        (rst_a),
    .hsync      (hsync_a),
    .vsync      (vsync_a),
    .active     (active_a),
    .x          (x_a),
    .y          (y_a),
    .line_tick  (line_tick_a),
    .frame_tick (frame_tick_a),
    .frame_cnt  (frame_cnt_a)
  );

  vga_timing #(
    .H_ACTIVE (BH_ACT), .H_FP (BH_FP), .H_SYNC (BH_SYNC), .H_BP (BH_BP),
    .V_ACTIVE (BV_ACT), .V_FP (BV_FP), .V_SYNC (BV_SYNC), .V_BP (BV_BP)
  ) u_dut_b (
    .clk        (clk),
    .rst        (rst_b),
    .hsync      (hsync_b),
    .vsync      (vsync_b),
    .active     (active_b),
    .x          (x_b),
    .y          (y_b),
    .line_tick  (line_tick_b),
    .frame_tick (frame_tick_b),
    .frame_cnt  (frame_cnt_b)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Walk one full 800-pixel line of instance A starting at x=0 on line y0.
  task automatic line_a(input string tag, input int y0);
    int x_err = 0, y_err = 0, lt_err = 0, act_err = 0;
    int hs_low = 0, hs_first = -1, hs_fall = 0;
    logic prev_hs = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if (x_a !== 10'(i)) x_err++;
      if (y_a !== 10'(y0)) y_err++;
      if (hsync_a === 1'b0) begin
        hs_low++;
        if (hs_first < 0) hs_first = i;
      end
      if (prev_hs === 1'b1 && hsync_a === 1'b0) hs_fall++;
      prev_hs = hsync_a;
      if (line_tick_a !== ((i == 799) ? 1'b1 : 1'b0)) lt_err++;
      if (active_a !== ((i < 640) ? 1'b1 : 1'b0)) act_err++;
      @(negedge clk);
    end
    chk({tag, "_x_seq"},       x_err,    0);
    chk({tag, "_y_steady"},    y_err,    0);
    chk({tag, "_hsync_len"},   hs_low,   96);
    chk({tag, "_hsync_start"}, hs_first, 656);
    chk({tag, "_hsync_pulses"},hs_fall,  1);
    chk({tag, "_line_tick"},   lt_err,   0);
    chk({tag, "_active_edge"}, act_err,  0);
    chk({tag, "_wrap_x"},      x_a,      0);
    chk({tag, "_wrap_y"},      y_a,      y0 + 1);
  endtask

  // Walk one full frame of instance B starting at (0,0); k is the frame index
  // (1-based), so frame_cnt should read k after this frame's tick.
  task automatic frame_b(input string tag, input int k);
    int pos_err = 0, hs_err = 0, vs_err = 0, act_err = 0, lt_err = 0, ft_err = 0;
    int act_cnt = 0, vs_low = 0, ft_cnt = 0;
    logic [15:0] cnt_after = 16'hDEAD;
    chk({tag, "_fcnt_before"}, frame_cnt_b, FCNT_EN * (k - 1));
    for (int v = 0; v < BV_TOT; v++) begin
      for (int h = 0; h < BH_TOT; h++) begin
        if (x_b !== 10'(h) || y_b !== 10'(v)) pos_err++;
        if (hsync_b !== ((h >= 10 && h < 13) ? 1'b0 : 1'b1)) hs_err++;
        if (vsync_b !== ((v >= 8 && v < 10) ? 1'b0 : 1'b1)) vs_err++;
        if (active_b !== ((h < 8 && v < 6) ? 1'b1 : 1'b0)) act_err++;
        if (line_tick_b !== ((h == 14) ? 1'b1 : 1'b0)) lt_err++;
        if (frame_tick_b !== ((h == 0 && v == 6) ? 1'b1 : 1'b0)) ft_err++;
        if (active_b === 1'b1) act_cnt++;
        if (vsync_b === 1'b0) vs_low++;
        if (frame_tick_b === 1'b1) ft_cnt++;
        if (h == 1 && v == 6) cnt_after = frame_cnt_b;
        @(negedge clk);
      end
    end
    chk({tag, "_pos"},         pos_err,   0);
    chk({tag, "_hsync"},       hs_err,    0);
    chk({tag, "_vsync"},       vs_err,    0);
    chk({tag, "_vsync_len"},   vs_low,    2 * BH_TOT);
    chk({tag, "_active"},      act_err,   0);
    chk({tag, "_active_cnt"},  act_cnt,   BH_ACT * BV_ACT);
    chk({tag, "_line_tick"},   lt_err,    0);
    chk({tag, "_frame_tick"},  ft_err,    0);
    chk({tag, "_ftick_cnt"},   ft_cnt,    1);
    chk({tag, "_fcnt_after"},  cnt_after, FCNT_EN * k);
    chk({tag, "_wrap_x"},      x_b,       0);
    chk({tag, "_wrap_y"},      y_b,       0);
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;

    // Three reset cycles on A: counters pinned at 0, no ticks.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_hold_x",  x_a, 0);
      chk("rst_hold_y",  y_a, 0);
      chk("rst_hold_lt", line_tick_a, 0);
      chk("rst_hold_ft", frame_tick_a, 0);
    end
    chk("rst_hsync",  hsync_a, 1);
    chk("rst_vsync",  vsync_a, 1);
    chk("rst_active", active_a, 1);
    chk("rst_fcnt",   frame_cnt_a, 0);
    rst_a = 1'b0;

    // First cycle after release was just sampled at (0,0); next is x=1.
    @(negedge clk);
    chk("release_x1", x_a, 1);
    chk("release_y0", y_a, 0);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;

    // Line 0, then partway into line 1.
    line_a("line0", 0);
    for (int i = 0; i < 300; i++) @(negedge clk);
    chk("mid_x", x_a, 300);
    chk("mid_y", y_a, 1);

    // One-cycle mid-frame reset: next cycle back at (0,0), timing repeats.
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    chk("midrst_x",  x_a, 0);
    chk("midrst_y",  y_a, 0);
    chk("midrst_lt", line_tick_a, 0);
    line_a("after_rst", 0);

    // B has been held in reset for the whole run so far.
    chk("b_long_rst_x",  x_b, 0);
    chk("b_long_rst_y",  y_b, 0);
    chk("b_long_rst_ft", frame_tick_b, 0);
    chk("b_long_rst_vs", vsync_b, 1);
    rst_b = 1'b0;

    // Three full frames on B starting from the post-reset (0,0) cycle.
    frame_b("frame1", 1);
    frame_b("frame2", 2);
    frame_b("frame3", 3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
